display_scan_driver: RTL and testbench
======================================

DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000: clk cycles per digit slot, minimum 4.
REQ-002 The block SHALL have parameter BLANK_CYC, default 500: cycles at the start of each slot with all anodes off (anti-ghosting), at most REFRESH_DIV-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port uni, input, 4 bits: BCD units digit.
REQ-006 The block SHALL have port dec, input, 4 bits: BCD tens digit.
REQ-007 The block SHALL have port cen, input, 4 bits: BCD hundreds digit.
REQ-008 The block SHALL have port mil, input, 4 bits: BCD thousands digit.
REQ-009 The block SHALL have port load, input, 1 bit: single-cycle strobe that captures uni, dec, cen and mil.
REQ-010 The block SHALL have port blank_lz, input, 1 bit: enables leading-zero suppression.
REQ-011 The block SHALL have port an, output, 4 bits: active-low anodes; an[0] is uni and an[3] is mil.
REQ-012 The block SHALL have port seg, output, 7 bits: active-low segments; seg[6:0] is g,f,e,d,c,b,a.
REQ-013 The block SHALL have port dp, output, 1 bit: active-low decimal point, held at 1 (off).

Function
REQ-014 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick SHALL be asserted when count equals REFRESH_DIV-1.
REQ-015 The 2-bit digit index SHALL advance 0->1->2->3->0 on each tick; the frame boundary is the tick taken while the index is 3.
REQ-016 On load=1, the four inputs SHALL be captured into a pending register and the pending flag set; a later load before transfer SHALL overwrite the pending value.
REQ-017 At the frame boundary with the pending flag set, the pending value SHALL be copied to the display register and the flag cleared; the display never changes mid-frame (no tearing).
REQ-018 If load coincides with the frame boundary, the current input values SHALL go directly to the display register and the pending flag SHALL be cleared.
REQ-019 The active digit's anode SHALL be driven 0 only while count >= BLANK_CYC; otherwise an SHALL be 4'b1111.
REQ-020 Decode SHALL map 0..9 to standard 7-segment patterns, e.g. 0 -> 7'b1000000 and 8 -> 7'b0000000; codes 10..15 SHALL give seg=7'b0111111 (dash, g on only).
REQ-021 With blank_lz=1, a digit SHALL be blanked (seg=7'b1111111) if it and all higher digits are 0; uni SHALL never be blanked.
REQ-022 blank_lz SHALL be sampled every cycle and need not be frame-aligned.
REQ-023 an and seg SHALL be registered; outputs SHALL reflect the count and index of the previous cycle (1-cycle latency).

Reset
REQ-024 While rst_n=0, the prescaler, digit index, pending register, pending flag and display register SHALL be 0.
REQ-025 While rst_n=0, an SHALL be 4'b1111, seg SHALL be 7'b1111111 and dp SHALL be 1.
REQ-026 Reset asserted mid-frame SHALL discard pending data and restart scanning at index 0, count 0 after release.

Structure
REQ-027 Segment pattern constants (digits 0-9, dash, blank) SHALL live in a shared header used by all display blocks.
REQ-028 Decode SHALL be one combinational sub-module, bcd_to_7seg (4-bit in, 7-bit active-low out), instantiated once after the digit mux.
REQ-029 The prescaler, index, pending/display registers and output registers SHALL sit in the top level.

Verification
(Benches use REFRESH_DIV=8, BLANK_CYC=2.)
REQ-030 Reset then release, no load -> an cycles 1110,1101,1011,0111 every 8 clk, each low for 6 cycles; seg=7'b1000000 throughout.
REQ-031 load with mil=1, cen=2, dec=3, uni=4 at mid-frame -> old digits kept until frame boundary; next frame shows "1234".
REQ-032 Two loads in one frame (5678 then 9012) -> only 9012 ever displayed.
REQ-033 blank_lz=1 with 0 0 4 0 -> mil and cen slots seg=7'b1111111; dec shows 4; uni shows 0.
REQ-034 uni=4'hB -> uni slot seg=7'b0111111; load on boundary tick -> value visible in the immediately following frame.
REQ-035 rst_n pulsed low mid-slot with pending set -> outputs off asynchronously; after release "0000" is shown and pending is discarded.

Source files
------------

// File: rtl/display_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// display_scan_driver_pkg
//
// Shared definitions for the 4-digit multiplexed 7-segment display blocks.
// All segment patterns are active-low and ordered {g,f,e,d,c,b,a} on bits
// [6:0], so a 0 bit lights the segment.
//
// Contents:
//   SEG_0 .. SEG_9  decimal digit patterns
//   SEG_DASH        shown for non-BCD codes 10..15 (only g lit)
//   SEG_BLANK       all segments off
//   AN_OFF          all anodes off (active-low)
//   DP_OFF          decimal point off (active-low)
//   bcd4_t          four BCD digits, thousands first
//   digit_e         scan slot index, 0 = units .. 3 = thousands
//   anode_for()     active-low one-hot anode pattern for a scan slot
// -----------------------------------------------------------------------------
package display_scan_driver_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic       DP_OFF = 1'b1;

  // Four BCD digits held as one word so capture/transfer is a single move.
  typedef struct packed {
    logic [3:0] mil;
    logic [3:0] cen;
    logic [3:0] dec;
    logic [3:0] uni;
  } bcd4_t;

  // Scan slot order; the numeric value is also the anode bit position.
  typedef enum logic [1:0] {
    DIG_UNI = 2'd0,
    DIG_DEC = 2'd1,
    DIG_CEN = 2'd2,
    DIG_MIL = 2'd3
  } digit_e;

  // Active-low anode pattern selecting exactly one digit.
  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/display_scan_driver_bcd_to_7seg.sv
// -----------------------------------------------------------------------------
// bcd_to_7seg
//
// Purely combinational BCD to 7-segment decoder, active-low outputs.
// Codes 0..9 give the usual digit shapes; 10..15 are not valid BCD and show a
// dash so a bad input is visible on the display rather than silently wrong.
//
// Ports:
//   bcd  in   4-bit BCD code
//   seg  out  7-bit active-low pattern {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_7seg
  import display_scan_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// -----------------------------------------------------------------------------
// display_scan_driver
//
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A prescaler divides clk into digit slots of REFRESH_DIV cycles; four slots
// make one frame (units, tens, hundreds, thousands). The first BLANK_CYC
// cycles of every slot keep all anodes off so the previous digit's segment
// pattern never ghosts onto the next digit.
//
// New digit values are captured on a load strobe into a pending register and
// only transferred to the display register at the end of a frame, so a frame
// never shows a mix of old and new digits.
//
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= 4)
//   BLANK_CYC    anode-off cycles at the start of each slot (<= REFRESH_DIV-1)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   uni       in   BCD units digit
//   dec       in   BCD tens digit
//   cen       in   BCD hundreds digit
//   mil       in   BCD thousands digit
//   load      in   single-cycle strobe capturing uni/dec/cen/mil
//   blank_lz  in   leading-zero suppression enable (live, not frame-aligned)
//   an        out  active-low anodes, an[0] = units .. an[3] = thousands
//   seg       out  active-low segments {g,f,e,d,c,b,a}
//   dp        out  active-low decimal point, always off
//
// an and seg are registered: they reflect the prescaler count and digit index
// of the previous cycle.
// -----------------------------------------------------------------------------
module display_scan_driver
  import display_scan_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] uni,
  input  logic [3:0] dec,
  input  logic [3:0] cen,
  input  logic [3:0] mil,
  input  logic       load,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int             CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYC);

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------
  logic [CW-1:0] count;
  logic [1:0]    idx;
  logic          tick;
  logic          frame_end;

  assign tick      = (count == CNT_MAX);
  // The tick taken in the thousands slot closes the frame.
  assign frame_end = tick && (idx == DIG_MIL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      idx   <= '0;
    end else begin
      if (tick) begin
        count <= '0;
        idx   <= idx + 2'd1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending / display registers
  // ---------------------------------------------------------------------------
  bcd4_t in_bcd;
  bcd4_t pend;
  bcd4_t disp;
  logic  pend_vld;

  assign in_bcd = {mil, cen, dec, uni};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_vld <= 1'b0;
      disp     <= '0;
    end else if (frame_end) begin
      // A load landing exactly on the boundary is newer than anything pending,
      // so it bypasses the pending register and the pending value is dropped.
      if (load) begin
        disp     <= in_bcd;
        pend_vld <= 1'b0;
      end else if (pend_vld) begin
        disp     <= pend;
        pend_vld <= 1'b0;
      end
    end else if (load) begin
      // Later loads in the same frame simply overwrite; only the last survives.
      pend     <= in_bcd;
      pend_vld <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select, leading-zero suppression and decode
  // ---------------------------------------------------------------------------
  logic [3:0] digit;
  logic       lead_zero;
  logic [6:0] dec_seg;
  logic [6:0] seg_next;
  logic [3:0] an_next;

  // lead_zero marks a digit that is zero along with every digit above it.
  // The units slot never sets it, so a value of 0 still shows a single "0".
  always_comb begin
    digit     = disp.uni;
    lead_zero = 1'b0;
    case (idx)
      DIG_UNI: begin
        digit     = disp.uni;
        lead_zero = 1'b0;
      end
      DIG_DEC: begin
        digit     = disp.dec;
        lead_zero = (disp.mil == 4'd0) && (disp.cen == 4'd0) && (disp.dec == 4'd0);
      end
      DIG_CEN: begin
        digit     = disp.cen;
        lead_zero = (disp.mil == 4'd0) && (disp.cen == 4'd0);
      end
      DIG_MIL: begin
        digit     = disp.mil;
        lead_zero = (disp.mil == 4'd0);
      end
      default: begin
        digit     = disp.uni;
        lead_zero = 1'b0;
      end
    endcase
  end

  bcd_to_7seg u_decode (
    .bcd (digit),
    .seg (dec_seg)
  );

  always_comb begin
    seg_next = (blank_lz && lead_zero) ? SEG_BLANK : dec_seg;
    // Anodes stay off for the first BLANK_CYC cycles of every slot.
    an_next  = (count >= BLANK_END) ? anode_for(idx) : AN_OFF;
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

  assign dp = DP_OFF;

endmodule

// File: tb/tb_display_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_display_scan_driver
//
// Directed bench for display_scan_driver with REFRESH_DIV=8, BLANK_CYC=2.
// Timing reference: cyc counts rising edges since reset release. Frame f spans
// cyc 32f+1 .. 32f+32; the lit part of slot j in frame f is seen at the
// falling edges with cyc = 32f+8j+3 .. 32f+8j+8. A load raised at the falling
// edge with cyc = n is sampled on the rising edge n+1; n = 32f+31 hits the
// frame boundary.
// -----------------------------------------------------------------------------
module tb_display_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] uni = 4'd0;
  logic [3:0] dec = 4'd0;
  logic [3:0] cen = 4'd0;
  logic [3:0] mil = 4'd0;
  logic       load = 1'b0;
  logic       blank_lz = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run = 0;
  logic [11:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  display_scan_driver #(
    .REFRESH_DIV (8),
    .BLANK_CYC   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uni      (uni),
    .dec      (dec),
    .cen      (cen),
    .mil      (mil),
    .load     (load),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Expected {an, seg, dp} for each slot of one frame, thousands pattern first.
  task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0);
    exp_q.push_back({4'b1110, s0, 1'b1});
    exp_q.push_back({4'b1101, s1, 1'b1});
    exp_q.push_back({4'b1011, s2, 1'b1});
    exp_q.push_back({4'b0111, s3, 1'b1});
  endtask

  task automatic do_load(input int at, input logic [3:0] m, input logic [3:0] c,
                         input logic [3:0] d, input logic [3:0] u);
    wait_cyc(at);
    mil  = m;
    cen  = c;
    dec  = d;
    uni  = u;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic check_off(input string name);
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      errors++;
      $display("FAIL %s got an=%b seg=%b dp=%b exp an=1111 seg=1111111 dp=1",
               name, an, seg, dp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: one compare per lit cycle, one run-length check and
  // one pop per slot.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
      end else if (an !== 4'b1111) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL slot_unexpected got an=%b seg=%b dp=%b with empty queue",
                   an, seg, dp);
        end else if ({an, seg, dp} !== exp_q[0]) begin
          errors++;
          $display("FAIL slot_value cyc=%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
                   cyc, an, seg, dp, exp_q[0][11:8], exp_q[0][7:1], exp_q[0][0]);
        end
        run++;
      end else if (run > 0) begin
        checks++;
        if (run != 6) begin
          errors++;
          $display("FAIL slot_length cyc=%0d got %0d lit cycles exp 6", cyc, run);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        run = 0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "bench timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    repeat (2) @(negedge clk);
    check_off("reset_hold_a");
    @(negedge clk);
    check_off("reset_hold_b");
    rst_n = 1'b1;

    // Frame 0: power-up display is 0000.
    push_frame(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);

    // Frame 1: load 1234 mid-frame; this frame still shows 0000.
    wait_cyc(32);
    push_frame(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    do_load(45, 4'd1, 4'd2, 4'd3, 4'd4);

    // Frame 2: shows 1234; two loads, only the second may appear.
    wait_cyc(64);
    push_frame(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);
    do_load(69, 4'd5, 4'd6, 4'd7, 4'd8);
    do_load(84, 4'd9, 4'd0, 4'd1, 4'd2);

    // Frame 3: shows 9012; load 0040 for the suppression test.
    wait_cyc(96);
    push_frame(7'b0010000, 7'b1000000, 7'b1111001, 7'b0100100);
    do_load(106, 4'd0, 4'd0, 4'd4, 4'd0);

    // Frame 4: blank_lz on, 0040 -> blank blank 4 0; load 000B on the boundary.
    wait_cyc(128);
    blank_lz = 1'b1;
    push_frame(7'b1111111, 7'b1111111, 7'b0011001, 7'b1000000);
    do_load(159, 4'd0, 4'd0, 4'd0, 4'hB);

    // Frame 5: boundary load visible at once; units never blanked, B -> dash.
    wait_cyc(160);
    push_frame(7'b1111111, 7'b1111111, 7'b1111111, 7'b0111111);

    // Frame 6: suppression off, 000B; set pending then reset mid-slot.
    wait_cyc(192);
    blank_lz = 1'b0;
    push_frame(7'b1000000, 7'b1000000, 7'b1000000, 7'b0111111);
    do_load(197, 4'd7, 4'd7, 4'd7, 4'd7);
    wait_cyc(204);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_off("async_reset");
    repeat (3) @(negedge clk);
    check_off("reset_held");
    rst_n = 1'b1;

    // Two frames after release: 0000, pending 7777 must never appear.
    push_frame(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    push_frame(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    wait_cyc(66);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d slots left exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
